burst_rd_responder: RTL and testbench
=====================================

Name: burst_rd_responder

Overview:
- Memory-side responder for the cache burst-read interface.
- Accepts one 32-byte-aligned read request through a valid/ready handshake.
- Returns BURST_LEN 32-bit beats with a last flag, under valid/ready back-pressure, from an internal word-addressed RAM.
- Serves as the memory endpoint behind the I-Cache in block-level simulation and as a simple on-chip instruction store.
- Includes a preload write port for initialising contents.

Parameters:
- ADDR_WIDTH, 10, word-address width of the internal RAM (depth = 2^ADDR_WIDTH words).
- BURST_LEN, 8, beats per burst. Fixed at 8 to match 32-byte lines.
- REQ_LATENCY, 2, idle cycles between request acceptance and the first response beat. Range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rd_req_valid  in  1  read request valid.
- rd_req_addr  in  32  request byte address. Bits [4:0] are ignored (treated as 0).
- rd_req_ready  out  1  responder can accept a request.
- rd_rsp_valid  out  1  current beat valid.
- rd_rsp_data  out  32  current beat data.
- rd_rsp_last  out  1  current beat is the final beat of the burst.
- rd_rsp_ready  in  1  requester accepts the current beat.
- init_wen  in  1  preload write enable.
- init_addr  in  ADDR_WIDTH  preload word address.
- init_wdata  in  32  preload data.

Behaviour:
- Reset
  - rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_last=0.
  - FSM goes to IDLE; latency and beat counters cleared.
  - RAM contents are not reset.
  - rd_req_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE, WAIT, SEND.
- IDLE
  - rd_req_ready=1.
  - On rd_req_valid && rd_req_ready (cycle T), latch base word index = rd_req_addr[ADDR_WIDTH+1:5] concatenated with 3'b000, and clear the beat counter.
  - If REQ_LATENCY>0, go to WAIT with the counter loaded to REQ_LATENCY-1. Otherwise go straight to SEND.
- WAIT
  - rd_req_ready=0.
  - Counter decrements each cycle; go to SEND when it reaches 0.
  - First rd_rsp_valid is at cycle T+1+REQ_LATENCY.
- Data path into SEND
  - On entry to SEND, rd_rsp_data is registered from RAM[base+0].
- SEND
  - rd_rsp_valid=1 and rd_req_ready=0.
  - rd_rsp_data and rd_rsp_last stay stable while rd_rsp_ready=0. Stalls have no upper bound.
  - On each handshake (rd_rsp_valid && rd_rsp_ready): the beat counter increments and the next beat RAM[base+cnt+1] is registered, so the next beat is valid in the following cycle with no bubble.
  - rd_rsp_last=1 exactly when the beat counter equals BURST_LEN-1.
- End of burst
  - On handshake of the last beat: go to IDLE; rd_rsp_valid and rd_rsp_last go to 0 next cycle; rd_rsp_data holds its last value.
  - rd_req_ready=1 next cycle, giving a one-cycle minimum gap between bursts.
- Address handling
  - Word index arithmetic is modulo 2^ADDR_WIDTH. Address bits above ADDR_WIDTH+1 are ignored, so the address space aliases.
  - A burst never crosses a line boundary.
- Preload port
  - Writes on any cycle and in any state, including during rst.
  - A write takes effect at the clock edge. A beat loaded in the same cycle as a write to the same word returns the pre-write value.
  - Writes issued after a beat is registered do not alter that beat.
- Request handling
  - Only one outstanding request at a time.
  - rd_req_valid while not ready is ignored; the requester must hold it.
  - rd_req_addr is sampled only at the handshake.
- rst asserted mid-WAIT or mid-SEND aborts the burst immediately; outputs take their reset values next cycle.

Test Plan:
- Preload RAM[i]=0x1000_0000+i for i=0..1023; request addr 0x0000_0040 at T with rd_rsp_ready=1 -> beats 0x10000010..0x10000017 on cycles T+3..T+10, last only with 0x10000017; rd_req_ready=1 at T+11.
- Same request, rd_rsp_ready toggled 1,0,0,1,... -> no beat dropped or duplicated; data and last stable across stalls; 8 beats in order.
- Request addr 0x0000_005C (misaligned) -> identical burst to 0x40; request 0x0000_1FE0 with ADDR_WIDTH=10 -> RAM[1016..1023]; request 0x0000_2000 -> RAM[0..7] (alias).
- REQ_LATENCY=0: handshake at T -> first beat at T+1; back-to-back requests held valid -> second request accepted exactly one cycle after the first last-beat handshake.
- Assert rst during beat 3 of a burst -> next cycle rd_rsp_valid=0, rd_rsp_last=0, rd_rsp_data=0; after release, a new request returns a full correct 8-beat burst.
- init_wen to word 0x12 with 0xDEAD_BEEF in the same cycle that beat 2 of a burst at 0x40 is registered -> that beat returns old 0x10000012; a subsequent burst returns 0xDEADBEEF.

Source files
------------

// File: rtl/burst_rd_responder.sv
// Memory-side burst-read responder: accepts one line-aligned request and streams
// BURST_LEN words from an internal word-addressed RAM under valid/ready back-pressure.
module burst_rd_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int BURST_LEN   = 8,
    parameter int REQ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_valid,
    input  logic [31:0]           rd_req_addr,
    output logic                  rd_req_ready,
    output logic                  rd_rsp_valid,
    output logic [31:0]           rd_rsp_data,
    output logic                  rd_rsp_last,
    input  logic                  rd_rsp_ready,
    input  logic                  init_wen,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [31:0]           init_wdata
);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [31:0]           data_q, data_d;

    logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0] req_base;
    logic [BEAT_W-1:0]     beat_nxt;
    logic                  req_hs;
    logic                  rsp_hs;
    logic                  unused_addr_bits;

    // Line offset and bits above the RAM's reach are dropped, so the space aliases.
    assign req_base         = {rd_req_addr[ADDR_WIDTH+1:BEAT_W+2], {BEAT_W{1'b0}}};
    assign unused_addr_bits = ^{rd_req_addr[31:ADDR_WIDTH+2], rd_req_addr[BEAT_W+1:0]};
    assign beat_nxt         = beat_q + BEAT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_d;
    end

    // Preload is independent of the FSM and of reset; reads below see the pre-write word.
    always_ff @(posedge clk) begin
        if (init_wen) begin
            mem[init_addr] <= init_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    base_d = req_base;
                    beat_d = '0;
                    if (REQ_LATENCY > 0) begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(REQ_LATENCY - 1);
                    end else begin
                        state_d = SEND;
                        data_d  = mem[req_base];
                    end
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = SEND;
                    data_d  = mem[base_q];
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            SEND: begin
                if (rsp_hs) begin
                    if (rd_rsp_last) begin
                        state_d = IDLE;
                    end else begin
                        // Index stays inside the line: only the beat bits advance.
                        beat_d = beat_nxt;
                        data_d = mem[{base_q[ADDR_WIDTH-1:BEAT_W], beat_nxt}];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_req_ready = (state_q == IDLE) && !rst;
        rd_rsp_valid = (state_q == SEND);
        rd_rsp_last  = (state_q == SEND) && (beat_q == BEAT_W'(BURST_LEN - 1));
        rd_rsp_data  = data_q;
        req_hs       = rd_req_valid && rd_req_ready;
        rsp_hs       = rd_rsp_valid && rd_rsp_ready;
    end

endmodule

// File: tb/tb_burst_rd_responder.sv
// Bench for burst_rd_responder: a latency-2 and a latency-0 instance checked against
// a word-array memory model with randomized addresses, stalls and preload writes.
module tb_burst_rd_responder;
    localparam int AW = 10;
    localparam int BL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sel;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          rsp_ready;
    logic          init_wen;
    logic [AW-1:0] init_addr;
    logic [31:0]   init_wdata;

    logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_last;
    logic [31:0]   a_rsp_data;
    logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_last;
    logic [31:0]   b_rsp_data;
    logic          m_req_ready, m_rsp_valid, m_rsp_last;
    logic [31:0]   m_rsp_data;

    assign a_req_valid = req_valid && !sel;
    assign b_req_valid = req_valid && sel;
    assign m_req_ready = sel ? b_req_ready : a_req_ready;
    assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_last  = sel ? b_rsp_last  : a_rsp_last;
    assign m_rsp_data  = sel ? b_rsp_data  : a_rsp_data;

    burst_rd_responder #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .REQ_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(a_req_valid), .rd_req_addr(req_addr), .rd_req_ready(a_req_ready),
        .rd_rsp_valid(a_rsp_valid), .rd_rsp_data(a_rsp_data), .rd_rsp_last(a_rsp_last),
        .rd_rsp_ready(rsp_ready),
        .init_wen(init_wen), .init_addr(init_addr), .init_wdata(init_wdata)
    );

    burst_rd_responder #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .REQ_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .rd_req_valid(b_req_valid), .rd_req_addr(req_addr), .rd_req_ready(b_req_ready),
        .rd_rsp_valid(b_rsp_valid), .rd_rsp_data(b_rsp_data), .rd_rsp_last(b_rsp_last),
        .rd_rsp_ready(rsp_ready),
        .init_wen(init_wen), .init_addr(init_addr), .init_wdata(init_wdata)
    );

    logic [31:0] model [0:(1<<AW)-1];
    logic [31:0] exp_beats [0:BL-1];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int base_of(input logic [31:0] addr);
        return int'((addr >> 5) & ((32'd1 << (AW - 3)) - 32'd1)) * BL;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input logic [31:0] addr);
        int b;
        b = base_of(addr);
        for (int i = 0; i < BL; i++) exp_beats[i] = model[b + i];
    endtask

    task automatic run_burst(input logic [31:0] addr, input int mode, input bit hold_next,
                             input logic [31:0] next_addr, input int race_beat,
                             input logic [31:0] race_data, output int wait_cyc);
        int lat, k, beat, vcnt, race_word;
        bit seen, done;
        lat = sel ? 0 : 2;
        load_exp(addr);
        race_word = base_of(addr) + race_beat;
        req_valid = 1'b1;
        req_addr  = addr;
        wait_cyc  = 0;
        while (!m_req_ready && wait_cyc < 20) begin
            tick;
            wait_cyc++;
        end
        n_cmp++;
        if (m_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL req_accept addr=%h: ready=%b after %0d cycles, want 1", addr, m_req_ready, wait_cyc);
            req_valid = 1'b0;
            return;
        end
        tick;
        if (hold_next) begin
            req_addr = next_addr;
        end else begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
        end
        k = 1; beat = 0; vcnt = 0; seen = 0; done = 0;
        while (!done && k < 300) begin
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = (vcnt % 3 == 0);
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_rsp_valid) begin
                if (!seen) begin
                    seen = 1;
                    n_cmp++;
                    if (k !== lat + 1) begin
                        n_bad++;
                        $display("FAIL first_beat_cycle addr=%h: got T+%0d want T+%0d", addr, k, lat + 1);
                    end
                end
                n_cmp++;
                if (m_rsp_data !== exp_beats[beat] || m_rsp_last !== (beat == BL - 1)) begin
                    n_bad++;
                    $display("FAIL beat%0d addr=%h: got data=%h last=%b want data=%h last=%b",
                             beat, addr, m_rsp_data, m_rsp_last, exp_beats[beat], (beat == BL - 1));
                end
                vcnt++;
                if (rsp_ready) begin
                    if (race_beat >= 1 && beat == race_beat - 1) begin
                        init_wen   = 1'b1;
                        init_addr  = AW'(race_word);
                        init_wdata = race_data;
                    end
                    beat++;
                    if (beat == BL) begin
                        done = 1;
                        if (!hold_next) req_valid = 1'b0;
                    end
                end
            end else if (seen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bubble addr=%h before beat%0d: got valid=0 want 1", addr, beat);
            end
            tick;
            k++;
            if (init_wen) begin
                model[race_word] = race_data;
                init_wen = 1'b0;
            end
        end
        rsp_ready = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL burst_timeout addr=%h: got %0d beats want %0d", addr, beat, BL);
        end else if (m_rsp_valid !== 1'b0 || m_rsp_last !== 1'b0 || m_req_ready !== 1'b1 ||
                     m_rsp_data !== exp_beats[BL-1]) begin
            n_bad++;
            $display("FAIL post_burst addr=%h: got valid=%b last=%b ready=%b data=%h want 0 0 1 %h",
                     addr, m_rsp_valid, m_rsp_last, m_req_ready, m_rsp_data, exp_beats[BL-1]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        init_wen = 1'b0; init_addr = '0; init_wdata = '0;
        tick;
        tick;
        n_cmp++;
        if ({a_req_ready, a_rsp_valid, a_rsp_last} !== 3'b000 || a_rsp_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_lat2: got ready=%b valid=%b last=%b data=%h want 0 0 0 0",
                     a_req_ready, a_rsp_valid, a_rsp_last, a_rsp_data);
        end
        n_cmp++;
        if ({b_req_ready, b_rsp_valid, b_rsp_last} !== 3'b000 || b_rsp_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_lat0: got ready=%b valid=%b last=%b data=%h want 0 0 0 0",
                     b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_data);
        end
        // Preload while still in reset.
        for (int i = 0; i < (1 << AW); i++) begin
            init_wen   = 1'b1;
            init_addr  = AW'(i);
            init_wdata = 32'h1000_0000 + i;
            tick;
            model[i] = 32'h1000_0000 + i;
        end
        init_wen = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b/%b want 1/1", a_req_ready, b_req_ready);
        end
    endtask

    task automatic test_basic;
        int w;
        sel = 1'b0;
        run_burst(32'h0000_0040, 0, 0, 0, -1, 0, w);
    endtask

    task automatic test_stall;
        int w;
        sel = 1'b0;
        run_burst(32'h0000_0040, 1, 0, 0, -1, 0, w);
        run_burst(32'h0000_0180, 2, 0, 0, -1, 0, w);
    endtask

    task automatic test_addr_alias;
        int w;
        sel = 1'b0;
        run_burst(32'h0000_005C, 2, 0, 0, -1, 0, w);
        run_burst(32'h0000_1FE0, 0, 0, 0, -1, 0, w);
        run_burst(32'h0000_2000, 1, 0, 0, -1, 0, w);
    endtask

    task automatic test_back_to_back;
        int w;
        sel = 1'b1;
        run_burst(32'h0000_0100, 0, 1, 32'h0000_03A0, -1, 0, w);
        run_burst(32'h0000_03A0, 2, 0, 0, -1, 0, w);
        n_cmp++;
        if (w !== 0) begin
            n_bad++;
            $display("FAIL b2b_lat0_gap: got %0d wait cycles want 0", w);
        end
        sel = 1'b0;
        run_burst(32'h0000_0080, 0, 1, 32'h0000_0060, -1, 0, w);
        run_burst(32'h0000_0060, 0, 0, 0, -1, 0, w);
        n_cmp++;
        if (w !== 0) begin
            n_bad++;
            $display("FAIL b2b_lat2_gap: got %0d wait cycles want 0", w);
        end
    endtask

    task automatic test_reset_mid;
        int k, hs, w;
        sel = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0040;
        k = 0;
        while (!m_req_ready && k < 20) begin tick; k++; end
        tick;
        req_valid = 1'b0;
        hs = 0; k = 0;
        while (hs < 3 && k < 50) begin
            if (m_rsp_valid) hs++;
            tick;
            k++;
        end
        rst = 1'b1;
        rsp_ready = 1'b0;
        tick;
        n_cmp++;
        if (hs != 3 || m_rsp_valid !== 1'b0 || m_rsp_last !== 1'b0 || m_rsp_data !== 32'h0 ||
            m_req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_burst: hs=%0d got valid=%b last=%b data=%h ready=%b want 3 0 0 0 0",
                     hs, m_rsp_valid, m_rsp_last, m_rsp_data, m_req_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (m_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_abort: got %b want 1", m_req_ready);
        end
        run_burst(32'h0000_0040, 0, 0, 0, -1, 0, w);
    endtask

    task automatic test_preload_race;
        int w;
        sel = 1'b0;
        run_burst(32'h0000_0040, 0, 0, 0, 2, 32'hDEAD_BEEF, w);
        run_burst(32'h0000_0040, 2, 0, 0, -1, 0, w);
    endtask

    task automatic test_random;
        int w;
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        for (int it = 0; it < 8; it++) begin
            sel = 1'($urandom_range(0, 1));
            for (int j = 0; j < 4; j++) begin
                wa = AW'($urandom);
                wd = $urandom;
                init_wen = 1'b1; init_addr = wa; init_wdata = wd;
                tick;
                model[wa] = wd;
                init_wen = 1'b0;
            end
            run_burst($urandom, int'($urandom_range(0, 2)), 0, 0, -1, 0, w);
        end
        sel = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_addr_alias;
        test_back_to_back;
        test_reset_mid;
        test_preload_race;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
